// File: rtl/mbi5153_pkg.sv
// Shared definitions for the MBI5153 command path.
// Contents: requester indices, command arbiter state encodings, and the
// default watchdog limit.
package mbi5153_pkg;

  localparam int N_REQ_DEF = 4;

  localparam logic [1:0] REQ_VSYNC = 2'd0;
  localparam logic [1:0] REQ_PREA  = 2'd1;
  localparam logic [1:0] REQ_RCFG  = 2'd2;
  localparam logic [1:0] REQ_DATA  = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;
  localparam logic [1:0] ST_WAIT_L = 2'd3;

  localparam int WDOG_CYCLES_DEF = 4096;

endpackage

// File: rtl/mbi5153_prio_enc.sv
// Fixed-priority encoder, lowest index wins.
// Ports:
//   req    - request vector
//   onehot - one-hot of the winning bit (0 when no request)
//   idx    - index of the winning bit (0 when no request)
//   valid  - at least one request bit set
module mbi5153_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = W'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbi5153_cmd_arb.sv
// Command arbiter sharing the MBI5153 LE-pulse transmitter among four
// requesters (VSYNC, PREA, RCFG, DATA). Latches request strobes, grants by
// fixed priority and keeps PREA immediately followed by RCFG.
// Optional feature macro: MBI5153_CMD_ARB_WDOG_EN (watchdog abort).
// Ports:
//   CLK, RESET       - clock, synchronous active-high reset
//   REQ              - one-cycle request strobes, bit i = requester i
//   REQ_READY        - bit i high: a strobe on REQ[i] will be accepted
//   REQ_DONE         - one-cycle strobe: command of requester i finished
//   TX_READY         - transmitter idle
//   TX_START, TX_ID  - start strobe and granted requester index
//   TX_DONE          - transmitter finished the command
//   LOCKED           - PREA->RCFG lock active
//   OVERRUN          - a strobe was dropped because REQ_READY was low
//   ABORT            - watchdog abort strobe
//
// state   | meaning
// IDLE    | pick highest-priority pending request when TX_READY
// WAIT    | command in flight, wait for TX_DONE
// LOCK    | PREA finished, only RCFG may be granted
// WAIT_L  | RCFG in flight under the lock
module mbi5153_cmd_arb
  import mbi5153_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] REQ_READY,
  output logic [N_REQ-1:0] REQ_DONE,
  input  logic             TX_READY,
  output logic             TX_START,
  output logic [1:0]       TX_ID,
  input  logic             TX_DONE,
  output logic             LOCKED,
  output logic             OVERRUN,
  output logic             ABORT
);

  localparam logic [N_REQ-1:0] RCFG_MASK = N_REQ'(1) << REQ_RCFG;

  logic [1:0]       state, state_nxt;
  logic [N_REQ-1:0] pending, grant_oh, eligible, enc_oh, done_mask;
  logic [1:0]       enc_idx;
  logic             enc_valid;
  logic             busy, start_fire, done_fire, wdog_hit;

  assign busy      = (state == ST_WAIT) || (state == ST_WAIT_L);
  assign LOCKED    = (state == ST_LOCK) || (state == ST_WAIT_L);
  assign REQ_READY = ~pending & ~(busy ? grant_oh : '0);
  assign eligible  = (state == ST_LOCK) ? (pending & RCFG_MASK) : pending;
  assign done_mask = done_fire ? grant_oh : '0;

  mbi5153_prio_enc #(.N(N_REQ), .W(2)) u_prio_enc (
    .req    (eligible),
    .onehot (enc_oh),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // A real TX_DONE wins over a watchdog hit in the same cycle, and a grant
  // out of LOCK wins over a lock timeout.
  always_comb begin
    state_nxt  = state;
    start_fire = 1'b0;
    done_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enc_valid && TX_READY) begin
          start_fire = 1'b1;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (TX_DONE) begin
          done_fire = 1'b1;
          state_nxt = (TX_ID == REQ_PREA) ? ST_LOCK : ST_IDLE;
        end else if (wdog_hit) begin
          done_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (enc_valid && TX_READY) begin
          start_fire = 1'b1;
          state_nxt  = ST_WAIT_L;
        end else if (wdog_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_L: begin
        if (TX_DONE || wdog_hit) begin
          done_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      pending  <= '0;
      grant_oh <= '0;
      TX_ID    <= '0;
      TX_START <= 1'b0;
      REQ_DONE <= '0;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= state_nxt;
      TX_START <= start_fire;
      if (start_fire) begin
        grant_oh <= enc_oh;
        TX_ID    <= enc_idx;
      end
      REQ_DONE <= done_mask;
      pending  <= (pending | (REQ & REQ_READY)) & ~done_mask;
      OVERRUN  <= |(REQ & ~REQ_READY);
    end
  end

`ifdef MBI5153_CMD_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              abort_q;

  assign wdog_hit = (state != ST_IDLE) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wdog_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      if (state_nxt != state)
        wdog_cnt <= '0;
      else if (state != ST_IDLE)
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      abort_q <= wdog_hit && !(busy && TX_DONE) && !start_fire;
    end
  end

  assign ABORT = abort_q;
`else
  assign wdog_hit = 1'b0;
  // Watchdog compiled out: the constant compare is always false.
  assign ABORT    = (WDOG_CYCLES < 0);
`endif

endmodule

// File: doc/mbi5153_cmd_arb.md
# mbi5153_cmd_arb

Command arbiter for the MBI5153 serial command transmitter. It shares the single LE-pulse command transmitter between four requesters: the VSYNC generator, the config sequencer's PREA and RCFG requests, and the grayscale data-latch writer. It latches single-cycle request strobes, grants them by fixed priority, and returns per-requester ready and done handshakes. It also enforces the driver rule that a PREA command is followed directly by the RCFG command, with no other command in between.

## Interface
Parameters:
- N_REQ, 4: number of requesters; fixed at 4 (package indices).
- WDOG_CYCLES, 4096: watchdog limit, in CLK cycles (used only with the macro).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, synchronous, active-high.
- REQ  in  N_REQ  one-cycle request strobes; bit i = requester i.
- REQ_READY  out  N_REQ  bit i high = strobe on REQ[i] will be accepted.
- REQ_DONE  out  N_REQ  one-cycle strobe; command of requester i has finished.
- TX_READY  in  1  transmitter idle and able to take TX_START.
- TX_START  out  1  one-cycle start strobe to the transmitter.
- TX_ID  out  2  index of the granted requester; the transmitter maps it to the LE width; held stable from TX_START until REQ_DONE.
- TX_DONE  in  1  one-cycle strobe; command shifted out and LE released.
- LOCKED  out  1  high while the arbiter is in the PREA→RCFG lock.
- OVERRUN  out  1  one-cycle strobe; a REQ bit arrived while its REQ_READY was low.
- ABORT  out  1  one-cycle watchdog abort strobe (tied 0 without the macro).

## Operation
- pending[i] is set on REQ[i] & REQ_READY[i]. It is cleared in the cycle REQ_DONE[i] is issued.
- REQ_READY[i] = ~pending[i] & ~(busy & TX_ID==i).
- A strobe on REQ[i] while REQ_READY[i] is low is dropped and pulses OVERRUN.
- Priority is fixed, lowest index first: VSYNC(0) > PREA(1) > RCFG(2) > DATA(3).
- FSM states:
  - IDLE: if eligible = pending is nonzero and TX_READY=1, register grant = highest-priority bit, TX_ID=grant, TX_START=1 → WAIT. Otherwise stay.
  - WAIT: TX_START returns to 0. On TX_DONE: REQ_DONE[TX_ID]=1 and pending[TX_ID] cleared. If TX_ID==PREA → LOCK, else → IDLE.
  - LOCK: LOCKED=1 and eligible = pending[RCFG] only; all other pending bits are held. If pending[RCFG] and TX_READY: TX_START, TX_ID=RCFG → WAIT_L.
  - WAIT_L: on TX_DONE: REQ_DONE[RCFG]=1 → IDLE. LOCKED stays high through WAIT_L and drops on entry to IDLE.
- Illegal state encoding → IDLE.
- A new request and a done for the same index in the same cycle: the request is an overrun, because REQ_READY is low while that index is served.
- A request from another index arriving during WAIT is latched and granted from IDLE after completion.

## Timing
- Reset values: REQ_READY=all 1s (after first clock in reset), all other outputs 0, TX_ID=0, pending=0, state IDLE.
- Reset asserted mid-command discards pending, grant and lock. No REQ_DONE is issued for an aborted command.
- Latency:
  - REQ[i] at cycle 0 with TX_READY=1 → pending at cycle 1 → TX_START at cycle 2.
  - TX_DONE at cycle n → REQ_DONE at cycle n+1.
  - Earliest next TX_START at cycle n+2.
- TX_START is asserted only if TX_READY was high in the deciding cycle. It is never asserted two cycles in a row.
- TX_DONE in IDLE or LOCK is ignored.

## Configuration
- MBI5153_CMD_ARB_WDOG_EN defined: a cycle counter runs in WAIT, LOCK and WAIT_L and resets on each state change.
  - Reaching WDOG_CYCLES pulses ABORT for one cycle.
  - In WAIT or WAIT_L it also pulses REQ_DONE[TX_ID], clears its pending bit → IDLE.
  - In LOCK it releases the lock → IDLE.
- MBI5153_CMD_ARB_WDOG_EN undefined: no counter. ABORT is constant 0, and WAIT and LOCK wait indefinitely.

## Structure
- Shared package mbi5153_pkg:
  - requester indices REQ_VSYNC=0, REQ_PREA=1, REQ_RCFG=2, REQ_DATA=3;
  - arbiter state encodings;
  - the default WDOG_CYCLES.
- One sub-module: mbi5153_prio_enc, a combinational N_REQ one-hot/index priority encoder with a valid flag, instantiated on the eligible vector.

## Test plan
- REQ=4'b0001 at cycle 0, TX_READY=1 → TX_START and TX_ID=0 at cycle 2; TX_DONE at cycle 10 → REQ_DONE=4'b0001 at cycle 11.
- REQ=4'b1001 in the same cycle → VSYNC served first, then DATA (TX_ID=3). Exactly two TX_START pulses.
- PREA served; then REQ=VSYNC and, 5 cycles later, REQ=RCFG → LOCKED=1, RCFG granted before VSYNC, then VSYNC; LOCKED low after the RCFG REQ_DONE.
- REQ[3] strobed again while DATA is pending → OVERRUN pulse, single DATA command sent.
- WDOG_EN, WDOG_CYCLES=16, TX_DONE withheld → ABORT and REQ_DONE at 16 cycles after entering WAIT; next pending granted.
- RESET for one cycle during WAIT → all outputs at reset values, no REQ_DONE, pending cleared.
